// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Supervises NUM_PLL PLLs from the free-running reference clock: pulses each
// PLL reset, synchronises and qualifies LOCK, holds the downstream domain in
// reset until lock has been stable, and re-locks on loss or timeout.
// Sticky loss/timeout flags and saturating re-lock counters feed status.
module pll_lock_supervisor #(
    parameter int NUM_PLL             = 2,
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 8
) (
    input  logic                     CLKI,
    input  logic                     RST,
    input  logic [NUM_PLL-1:0]       LOCK_IN,
    input  logic [NUM_PLL-1:0]       FORCE_RELOCK,
    input  logic                     CLR_STICKY,
    output logic [NUM_PLL-1:0]       PLL_RST,
    output logic [NUM_PLL-1:0]       DOMAIN_RST,
    output logic                     ALL_READY,
    output logic [NUM_PLL-1:0]       LOCK_LOST,
    output logic [NUM_PLL-1:0]       TIMEOUT_ERR,
    output logic [NUM_PLL*CNT_W-1:0] RELOCK_CNT
);

    // One counter per channel serves all three timed phases, so it is sized
    // for the longest of them.
    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]    RST_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0]    STB_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_PLLRST = 2'd0,
        S_WAIT   = 2'd1,
        S_STABLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    logic [NUM_PLL-1:0] r_sync [SYNC_STAGES];
    logic [NUM_PLL-1:0] w_lock_s;

    state_t             r_state     [NUM_PLL];
    state_t             w_state_nxt [NUM_PLL];
    logic [TW-1:0]      r_cnt       [NUM_PLL];
    logic [TW-1:0]      w_cnt_nxt   [NUM_PLL];
    logic [NUM_PLL-1:0] w_loss;
    logic [NUM_PLL-1:0] w_tmo;
    logic [NUM_PLL-1:0] w_pll_rst_nxt;
    logic [NUM_PLL-1:0] w_dom_rst_nxt;

    logic [NUM_PLL-1:0] r_pll_rst;
    logic [NUM_PLL-1:0] r_dom_rst;
    logic               r_all_ready;
    logic [NUM_PLL-1:0] r_lock_lost;
    logic [NUM_PLL-1:0] r_timeout_err;
    logic [CNT_W-1:0]   r_relock [NUM_PLL];

    // LOCK synchroniser chain; only its last stage is seen by the FSMs.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= LOCK_IN;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_lock_s = r_sync[SYNC_STAGES-1];

    // Per-channel state and phase counter registers.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            for (int i = 0; i < NUM_PLL; i++) begin
                r_state[i] <= S_PLLRST;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PLL; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    // Next-state logic; loss/timeout events are flagged even if a forced
    // re-lock lands on the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_PLL; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            w_loss[i]      = 1'b0;
            w_tmo[i]       = 1'b0;
            case (r_state[i])
                S_PLLRST: begin
                    if (r_cnt[i] == RST_LAST) begin
                        w_state_nxt[i] = S_WAIT;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (w_lock_s[i]) begin
                        w_state_nxt[i] = S_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == TMO_LAST) begin
                        w_state_nxt[i] = S_PLLRST;
                        w_cnt_nxt[i]   = '0;
                        w_tmo[i]       = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s[i]) begin
                        w_state_nxt[i] = S_WAIT;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == STB_LAST) begin
                        w_state_nxt[i] = S_RUN;
                        w_cnt_nxt[i]   = '0;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!w_lock_s[i]) begin
                        w_state_nxt[i] = S_PLLRST;
                        w_cnt_nxt[i]   = '0;
                        w_loss[i]      = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_PLLRST;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
            if (FORCE_RELOCK[i]) begin
                w_state_nxt[i] = S_PLLRST;
                w_cnt_nxt[i]   = '0;
            end
        end
    end

    // Output decode from the next state so the registered outputs change on
    // the same edge as the state.
    always_comb begin
        w_pll_rst_nxt = '0;
        w_dom_rst_nxt = '0;
        for (int i = 0; i < NUM_PLL; i++) begin
            w_pll_rst_nxt[i] = (w_state_nxt[i] == S_PLLRST);
            w_dom_rst_nxt[i] = (w_state_nxt[i] != S_RUN);
        end
    end

    // Registered outputs, sticky flags (set beats clear) and saturating counts.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            r_pll_rst     <= '1;
            r_dom_rst     <= '1;
            r_all_ready   <= 1'b0;
            r_lock_lost   <= '0;
            r_timeout_err <= '0;
            for (int i = 0; i < NUM_PLL; i++) r_relock[i] <= '0;
        end else begin
            r_pll_rst   <= w_pll_rst_nxt;
            r_dom_rst   <= w_dom_rst_nxt;
            r_all_ready <= ~|r_dom_rst;
            for (int i = 0; i < NUM_PLL; i++) begin
                r_lock_lost[i]   <= w_loss[i] | (r_lock_lost[i] & ~CLR_STICKY);
                r_timeout_err[i] <= w_tmo[i] | (r_timeout_err[i] & ~CLR_STICKY);
                if ((w_loss[i] | w_tmo[i]) && (r_relock[i] != CNT_MAX)) begin
                    r_relock[i] <= r_relock[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pack the per-channel counters onto the flat status bus.
    always_comb begin
        RELOCK_CNT = '0;
        for (int i = 0; i < NUM_PLL; i++) RELOCK_CNT[i*CNT_W +: CNT_W] = r_relock[i];
    end

    assign PLL_RST     = r_pll_rst;
    assign DOMAIN_RST  = r_dom_rst;
    assign ALL_READY   = r_all_ready;
    assign LOCK_LOST   = r_lock_lost;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule
